// File: rtl/jtag_dtm_pkg.sv
// Shared types and constants for the JTAG debug transport module:
// TAP state encoding, IR opcodes, DMI op codes, DMI FSM states and DTMCS layout.
package jtag_dtm_pkg;

    typedef enum logic [3:0] {
        TAP_TLR       = 4'h0,
        TAP_RTI       = 4'h1,
        TAP_SEL_DR    = 4'h2,
        TAP_CAP_DR    = 4'h3,
        TAP_SHIFT_DR  = 4'h4,
        TAP_EXIT1_DR  = 4'h5,
        TAP_PAUSE_DR  = 4'h6,
        TAP_EXIT2_DR  = 4'h7,
        TAP_UPD_DR    = 4'h8,
        TAP_SEL_IR    = 4'h9,
        TAP_CAP_IR    = 4'hA,
        TAP_SHIFT_IR  = 4'hB,
        TAP_EXIT1_IR  = 4'hC,
        TAP_PAUSE_IR  = 4'hD,
        TAP_EXIT2_IR  = 4'hE,
        TAP_UPD_IR    = 4'hF
    } tap_state_e;

    // Opcodes, zero-extended to the IR width at the point of use.
    // All-ones and every unlisted opcode select BYPASS.
    localparam int unsigned OP_IDCODE = 'h01;
    localparam int unsigned OP_DTMCS  = 'h10;
    localparam int unsigned OP_DMI    = 'h11;

    typedef enum logic [1:0] {
        DMI_OP_NOP   = 2'd0,
        DMI_OP_READ  = 2'd1,
        DMI_OP_WRITE = 2'd2,
        DMI_OP_BUSY  = 2'd3
    } dmi_op_e;

    typedef enum logic [1:0] {
        DMI_IDLE = 2'd0,
        DMI_REQ  = 2'd1,
        DMI_WAIT = 2'd2
    } dmi_state_e;

    // DTMCS field positions.
    localparam int DTMCS_VERSION_LSB   = 0;
    localparam int DTMCS_ABITS_LSB     = 4;
    localparam int DTMCS_DMISTAT_LSB   = 10;
    localparam int DTMCS_IDLE_LSB      = 12;
    localparam int DTMCS_DMIRESET_BIT  = 16;
    localparam int DTMCS_HARDRESET_BIT = 17;
    localparam logic [3:0] DTMCS_VERSION = 4'h1;

    // Read view of DTMCS; the reset request bits always read back as zero.
    function automatic logic [31:0] dtmcs_word(input logic [2:0] idle,
                                               input logic [1:0] dmistat,
                                               input logic [5:0] abits);
        logic [31:0] w;
        w = '0;
        w[DTMCS_VERSION_LSB +: 4] = DTMCS_VERSION;
        w[DTMCS_ABITS_LSB   +: 6] = abits;
        w[DTMCS_DMISTAT_LSB +: 2] = dmistat;
        w[DTMCS_IDLE_LSB    +: 3] = idle;
        return w;
    endfunction

endpackage

// File: rtl/jtag_dtm_if.sv
// DMI request/response bus between the DTM (master) and the debug module (slave).
interface jtag_dtm_if #(
    parameter int DMI_ADDR_BITS = 7,
    parameter int DMI_DATA_BITS = 32
);
    logic                                   dmi_req_valid_o;
    logic                                   dmi_req_ready_i;
    logic [DMI_ADDR_BITS+DMI_DATA_BITS+1:0] dmi_req_o;
    logic                                   dmi_resp_valid_i;
    logic                                   dmi_resp_ready_o;
    logic [DMI_DATA_BITS-1:0]               dmi_resp_data_i;
    logic [1:0]                             dmi_resp_op_i;

    modport master (
        output dmi_req_valid_o, dmi_req_o, dmi_resp_ready_o,
        input  dmi_req_ready_i, dmi_resp_valid_i, dmi_resp_data_i, dmi_resp_op_i
    );

    modport slave (
        input  dmi_req_valid_o, dmi_req_o, dmi_resp_ready_o,
        output dmi_req_ready_i, dmi_resp_valid_i, dmi_resp_data_i, dmi_resp_op_i
    );
endinterface

// File: rtl/jtag_tap_fsm.sv
// IEEE 1149.1 TAP controller: 16 states, one transition per rising TCK edge.
module jtag_tap_fsm
    import jtag_dtm_pkg::*;
(
    input  logic       tck_i,
    input  logic       rst_i,
    input  logic       tms_i,
    output tap_state_e state_o
);

    tap_state_e state_q;

    // Walk the TAP state graph under TMS; reset parks in Test-Logic-Reset.
    always_ff @(posedge tck_i) begin
        if (rst_i) begin
            state_q <= TAP_TLR;
        end else begin
            case (state_q)
                TAP_TLR:      state_q <= tms_i ? TAP_TLR      : TAP_RTI;
                TAP_RTI:      state_q <= tms_i ? TAP_SEL_DR   : TAP_RTI;
                TAP_SEL_DR:   state_q <= tms_i ? TAP_SEL_IR   : TAP_CAP_DR;
                TAP_CAP_DR:   state_q <= tms_i ? TAP_EXIT1_DR : TAP_SHIFT_DR;
                TAP_SHIFT_DR: state_q <= tms_i ? TAP_EXIT1_DR : TAP_SHIFT_DR;
                TAP_EXIT1_DR: state_q <= tms_i ? TAP_UPD_DR   : TAP_PAUSE_DR;
                TAP_PAUSE_DR: state_q <= tms_i ? TAP_EXIT2_DR : TAP_PAUSE_DR;
                TAP_EXIT2_DR: state_q <= tms_i ? TAP_UPD_DR   : TAP_SHIFT_DR;
                TAP_UPD_DR:   state_q <= tms_i ? TAP_SEL_DR   : TAP_RTI;
                TAP_SEL_IR:   state_q <= tms_i ? TAP_TLR      : TAP_CAP_IR;
                TAP_CAP_IR:   state_q <= tms_i ? TAP_EXIT1_IR : TAP_SHIFT_IR;
                TAP_SHIFT_IR: state_q <= tms_i ? TAP_EXIT1_IR : TAP_SHIFT_IR;
                TAP_EXIT1_IR: state_q <= tms_i ? TAP_UPD_IR   : TAP_PAUSE_IR;
                TAP_PAUSE_IR: state_q <= tms_i ? TAP_EXIT2_IR : TAP_PAUSE_IR;
                TAP_EXIT2_IR: state_q <= tms_i ? TAP_UPD_IR   : TAP_SHIFT_IR;
                TAP_UPD_IR:   state_q <= tms_i ? TAP_SEL_DR   : TAP_RTI;
                default:      state_q <= TAP_TLR;
            endcase
        end
    end

    assign state_o = state_q;

endmodule

// File: rtl/jtag_dtm.sv
// RISC-V style JTAG debug transport module: TAP, IR/DR scan chains, DTMCS and
// the DMI request/response engine with sticky error status.
// Optional feature: define JTAG_DTM_HARDRESET_EN to let DTMCS bit 17
// (dmihardreset) abort a hung DMI transaction; otherwise only rst_i recovers it.
module jtag_dtm
    import jtag_dtm_pkg::*;
#(
    parameter int          IR_BITS       = 5,
    parameter int          DMI_ADDR_BITS = 7,
    parameter int          DMI_DATA_BITS = 32,
    parameter logic [31:0] IDCODE_VAL    = 32'h1E200A6F,
    parameter logic [2:0]  IDLE_HINT     = 3'd5
) (
    input  logic         jtag_TCK,
    input  logic         rst_i,
    input  logic         jtag_TMS,
    input  logic         jtag_TDI,
    output logic         jtag_TDO,
    output logic         jtag_TDO_en,
    jtag_dtm_if.master   dmi
);

    localparam int DMI_W  = DMI_ADDR_BITS + DMI_DATA_BITS + 2;
    localparam int MAX_DR = (DMI_W > 32) ? DMI_W : 32;
    localparam int SR_W   = (MAX_DR > IR_BITS) ? MAX_DR : IR_BITS;

    tap_state_e               tap_state;
    logic [IR_BITS-1:0]       ir_q;
    logic [SR_W-1:0]          sr_q, sr_d, shifted;
    int                       shift_len;
    dmi_state_e               dmi_state_q;
    logic [1:0]               sticky_q;
    logic [DMI_W-1:0]         req_q;
    logic [DMI_ADDR_BITS-1:0] last_addr_q;
    logic [DMI_DATA_BITS-1:0] resp_data_q;

    logic                     sel_idcode, sel_dtmcs, sel_dmi, pending, upd_dr;
    logic [1:0]               upd_op;
    logic [DMI_ADDR_BITS-1:0] upd_addr;
    logic [31:0]              dtmcs_w;

    jtag_tap_fsm u_tap (
        .tck_i   (jtag_TCK),
        .rst_i   (rst_i),
        .tms_i   (jtag_TMS),
        .state_o (tap_state)
    );

    assign sel_idcode = (ir_q == IR_BITS'(OP_IDCODE));
    assign sel_dtmcs  = (ir_q == IR_BITS'(OP_DTMCS));
    assign sel_dmi    = (ir_q == IR_BITS'(OP_DMI));
    assign pending    = (dmi_state_q != DMI_IDLE);
    assign upd_dr     = (tap_state == TAP_UPD_DR);
    assign upd_op     = sr_q[1:0];
    assign upd_addr   = sr_q[DMI_W-1:DMI_DATA_BITS+2];
    assign dtmcs_w    = dtmcs_word(IDLE_HINT, sticky_q, 6'(DMI_ADDR_BITS));

    // Active chain length: IR while in the IR column, else the selected DR.
    always_comb begin
        shift_len = 1;
        if (tap_state == TAP_SHIFT_IR) shift_len = IR_BITS;
        else if (sel_dmi)              shift_len = DMI_W;
        else if (sel_idcode || sel_dtmcs) shift_len = 32;
    end

    // Right shift with TDI entering at the top of the active chain; bits above it stay zero.
    always_comb begin
        shifted = {1'b0, sr_q[SR_W-1:1]};
        for (int i = 0; i < SR_W; i++) begin
            if (i == shift_len - 1)  shifted[i] = jtag_TDI;
            else if (i >= shift_len) shifted[i] = 1'b0;
        end
    end

    // Capture/shift next value of the shared scan register.
    always_comb begin
        sr_d = sr_q;
        case (tap_state)
            TAP_CAP_IR:                 sr_d = SR_W'(2'b01);
            TAP_SHIFT_IR, TAP_SHIFT_DR: sr_d = shifted;
            TAP_CAP_DR: begin
                if (sel_dmi)
                    sr_d = SR_W'(pending ? {last_addr_q, resp_data_q, 2'b11}
                                         : {last_addr_q, resp_data_q, sticky_q});
                else if (sel_idcode) sr_d = SR_W'(IDCODE_VAL | 32'h1);
                else if (sel_dtmcs)  sr_d = SR_W'(dtmcs_w);
                else                 sr_d = '0;
            end
            default: ;
        endcase
    end

    // Scan register and instruction register; Test-Logic-Reset reselects IDCODE.
    always_ff @(posedge jtag_TCK) begin
        if (rst_i) begin
            sr_q <= '0;
            ir_q <= IR_BITS'(OP_IDCODE);
        end else begin
            sr_q <= sr_d;
            if (tap_state == TAP_TLR)         ir_q <= IR_BITS'(OP_IDCODE);
            else if (tap_state == TAP_UPD_IR) ir_q <= sr_q[IR_BITS-1:0];
        end
    end

    // DMI engine: bus handshakes first, then scan-driven updates take priority.
    always_ff @(posedge jtag_TCK) begin
        if (rst_i) begin
            dmi_state_q <= DMI_IDLE;
            sticky_q    <= 2'd0;
            req_q       <= '0;
            last_addr_q <= '0;
            resp_data_q <= '0;
        end else begin
            case (dmi_state_q)
                DMI_REQ: if (dmi.dmi_req_ready_i) dmi_state_q <= DMI_WAIT;
                DMI_WAIT: begin
                    if (dmi.dmi_resp_valid_i) begin
                        resp_data_q <= dmi.dmi_resp_data_i;
                        dmi_state_q <= DMI_IDLE;
                        if (dmi.dmi_resp_op_i != 2'd0 && sticky_q == 2'd0) sticky_q <= 2'd2;
                    end
                end
                default: ;
            endcase

            // A scan that overlaps a live transaction reports busy and latches it.
            if (tap_state == TAP_CAP_DR && sel_dmi && pending) sticky_q <= 2'd3;

            if (upd_dr && sel_dmi) begin
                if (pending) begin
                    sticky_q <= 2'd3;
                end else if (sticky_q == 2'd0 &&
                             (upd_op == DMI_OP_READ || upd_op == DMI_OP_WRITE)) begin
                    req_q       <= sr_q[DMI_W-1:0];
                    last_addr_q <= upd_addr;
                    dmi_state_q <= DMI_REQ;
                end
            end

            if (upd_dr && sel_dtmcs) begin
                if (sr_q[DTMCS_DMIRESET_BIT]) sticky_q <= 2'd0;
`ifdef JTAG_DTM_HARDRESET_EN
                if (sr_q[DTMCS_HARDRESET_BIT]) begin
                    sticky_q    <= 2'd0;
                    dmi_state_q <= DMI_IDLE;
                end
`endif
            end
        end
    end

    assign jtag_TDO_en          = (tap_state == TAP_SHIFT_IR) || (tap_state == TAP_SHIFT_DR);
    assign jtag_TDO             = jtag_TDO_en & sr_q[0];
    assign dmi.dmi_req_valid_o  = (dmi_state_q == DMI_REQ);
    assign dmi.dmi_req_o        = req_q;
    assign dmi.dmi_resp_ready_o = (dmi_state_q != DMI_REQ);

endmodule

// File: tb/tb_jtag_dtm.sv
// Directed bench for jtag_dtm: TAP reset, IDCODE/DTMCS/BYPASS scans, DMI
// request hold, busy/sticky handling, error response, hardreset and rst_i.
module tb_jtag_dtm;

    logic tck = 1'b0;
    logic rst = 1'b1;
    logic tms = 1'b1;
    logic tdi = 1'b0;
    logic tdo, tdo_en;
    int   total = 0;
    int   bad   = 0;
    logic en_mid;
    logic [63:0] dout;

    jtag_dtm_if #(.DMI_ADDR_BITS(7), .DMI_DATA_BITS(32)) dmi ();

    jtag_dtm dut (
        .jtag_TCK    (tck),
        .rst_i       (rst),
        .jtag_TMS    (tms),
        .jtag_TDI    (tdi),
        .jtag_TDO    (tdo),
        .jtag_TDO_en (tdo_en),
        .dmi         (dmi)
    );

    always #5 tck = ~tck;

    initial begin
        #2000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step(input logic m, input logic d);
        tms = m;
        tdi = d;
        @(posedge tck);
        @(negedge tck);
    endtask

    task automatic shift_ir(input logic [4:0] v);
        step(1, 0); step(1, 0); step(0, 0); step(0, 0);
        for (int i = 0; i < 5; i++) step(i == 4, v[i]);
        step(1, 0); step(0, 0);
    endtask

    task automatic shift_dr(input logic [63:0] din, input int len, output logic [63:0] q);
        q = '0;
        step(1, 0); step(0, 0); step(0, 0);
        for (int i = 0; i < len; i++) begin
            q[i] = tdo;
            if (i == 0) en_mid = tdo_en;
            step(i == len - 1, din[i]);
        end
        step(1, 0); step(0, 0);
    endtask

    function automatic logic [63:0] dw(input logic [6:0] a, input logic [31:0] d, input logic [1:0] op);
        return {23'b0, a, d, op};
    endfunction

    task automatic cycle();
        step(0, 0);
    endtask

    initial begin
        dmi.dmi_req_ready_i  = 1'b0;
        dmi.dmi_resp_valid_i = 1'b0;
        dmi.dmi_resp_data_i  = '0;
        dmi.dmi_resp_op_i    = '0;
        @(negedge tck);
        step(1, 0); step(1, 0);
        chk("rst_tdo", tdo, 0);
        chk("rst_tdo_en", tdo_en, 0);
        chk("rst_req_valid", dmi.dmi_req_valid_o, 0);
        chk("rst_req", dmi.dmi_req_o, 0);
        chk("rst_resp_ready", dmi.dmi_resp_ready_o, 1);
        rst = 1'b0;
        step(0, 0);

        // IDCODE selected after reset
        shift_dr(64'h0, 32, dout);
        chk("idcode_after_rst", dout, 64'h1E200A6F);
        chk("tdo_en_in_shift", en_mid, 1);
        chk("tdo_en_idle", tdo_en, 0);

        // Five TMS=1 from Shift-DR returns to TLR and reselects IDCODE
        shift_ir(5'h10);
        step(1, 0); step(0, 0); step(0, 0);
        for (int i = 0; i < 5; i++) step(1, 0);
        step(0, 0);
        shift_dr(64'h0, 32, dout);
        chk("idcode_after_tms_reset", dout, 64'h1E200A6F);

        // DTMCS defaults
        shift_ir(5'h10);
        shift_dr(64'h0, 32, dout);
        chk("dtmcs_default", dout, 64'h00005071);

        // BYPASS and an undefined opcode: one-bit chain capturing 0
        shift_ir(5'h1F);
        shift_dr(64'h1, 2, dout);
        chk("bypass", dout, 64'h2);
        shift_ir(5'h05);
        shift_dr(64'h1, 2, dout);
        chk("unknown_op_bypass", dout, 64'h2);

        // DMI write held while ready is low
        shift_ir(5'h11);
        shift_dr(dw(7'h10, 32'h1, 2'd2), 41, dout);
        chk("dmi_first_capture", dout, 64'h0);
        chk("req_valid_after_update", dmi.dmi_req_valid_o, 1);
        chk("resp_ready_in_req", dmi.dmi_resp_ready_o, 0);
        for (int i = 0; i < 3; i++) begin
            chk("req_stable", dmi.dmi_req_o, dw(7'h10, 32'h1, 2'd2));
            cycle();
        end
        chk("req_valid_held", dmi.dmi_req_valid_o, 1);
        dmi.dmi_req_ready_i = 1'b1;
        cycle();
        dmi.dmi_req_ready_i = 1'b0;
        chk("req_valid_after_accept", dmi.dmi_req_valid_o, 0);
        chk("resp_ready_in_wait", dmi.dmi_resp_ready_o, 1);

        // Rescan while WAIT: busy capture, write dropped
        shift_dr(dw(7'h11, 32'h5, 2'd2), 41, dout);
        chk("busy_capture_op", dout[1:0], 2'd3);
        chk("busy_write_dropped", dmi.dmi_req_valid_o, 0);
        dmi.dmi_resp_valid_i = 1'b1;
        dmi.dmi_resp_data_i  = 32'hCAFE;
        dmi.dmi_resp_op_i    = 2'd0;
        cycle();
        dmi.dmi_resp_valid_i = 1'b0;
        shift_dr(dw(7'h12, 32'h7, 2'd2), 41, dout);
        chk("sticky_capture", dout, dw(7'h10, 32'hCAFE, 2'd3));
        chk("sticky_write_ignored", dmi.dmi_req_valid_o, 0);

        // dmireset clears sticky, then a read issues
        shift_ir(5'h10);
        shift_dr(64'h10000, 32, dout);
        chk("dtmcs_dmistat_busy", dout, 64'h00005C71);
        shift_dr(64'h0, 32, dout);
        chk("dtmcs_after_dmireset", dout, 64'h00005071);
        shift_ir(5'h11);
        shift_dr(dw(7'h12, 32'h7, 2'd1), 41, dout);
        chk("capture_after_clear", dout, dw(7'h10, 32'hCAFE, 2'd0));
        chk("read_issued_valid", dmi.dmi_req_valid_o, 1);
        chk("read_issued_req", dmi.dmi_req_o, dw(7'h12, 32'h7, 2'd1));

        // Failed response latches dmistat=2
        dmi.dmi_req_ready_i = 1'b1;
        cycle();
        dmi.dmi_req_ready_i  = 1'b0;
        dmi.dmi_resp_valid_i = 1'b1;
        dmi.dmi_resp_data_i  = 32'hBEEF;
        dmi.dmi_resp_op_i    = 2'd2;
        cycle();
        dmi.dmi_resp_valid_i = 1'b0;
        shift_ir(5'h10);
        shift_dr(64'h0, 32, dout);
        chk("dtmcs_dmistat_failed", dout, 64'h00005871);

        // Response while IDLE is discarded
        dmi.dmi_resp_valid_i = 1'b1;
        dmi.dmi_resp_data_i  = 32'h1234;
        dmi.dmi_resp_op_i    = 2'd0;
        cycle();
        dmi.dmi_resp_valid_i = 1'b0;
        shift_ir(5'h11);
        shift_dr(64'h0, 41, dout);
        chk("capture_failed_op", dout, dw(7'h12, 32'hBEEF, 2'd2));

        // Hung WAIT and dmihardreset
        shift_ir(5'h10);
        shift_dr(64'h10000, 32, dout);
        shift_ir(5'h11);
        shift_dr(dw(7'h20, 32'hA5A5, 2'd2), 41, dout);
        chk("capture_before_hang", dout, dw(7'h12, 32'hBEEF, 2'd0));
        dmi.dmi_req_ready_i = 1'b1;
        cycle();
        dmi.dmi_req_ready_i = 1'b0;
        shift_ir(5'h10);
        shift_dr(64'h20000, 32, dout);
        shift_dr(64'h0, 32, dout);
        chk("dtmcs_after_hardreset", dout, 64'h00005071);
        shift_ir(5'h11);
        shift_dr(64'h0, 41, dout);
`ifdef JTAG_DTM_HARDRESET_EN
        chk("hardreset_capture", dout, dw(7'h20, 32'hBEEF, 2'd0));
`else
        chk("hardreset_ignored_capture", dout, dw(7'h20, 32'hBEEF, 2'd3));
`endif

        // rst_i in the middle of a request
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        step(0, 0);
        shift_ir(5'h11);
        shift_dr(dw(7'h30, 32'h1, 2'd2), 41, dout);
        chk("capture_after_rst", dout, 64'h0);
        chk("valid_before_mid_rst", dmi.dmi_req_valid_o, 1);
        rst = 1'b1;
        cycle();
        chk("valid_after_mid_rst", dmi.dmi_req_valid_o, 0);
        chk("req_after_mid_rst", dmi.dmi_req_o, 64'h0);
        rst = 1'b0;
        dmi.dmi_req_ready_i = 1'b1;
        step(0, 0);
        dmi.dmi_req_ready_i = 1'b0;
        chk("valid_stays_low", dmi.dmi_req_valid_o, 0);
        shift_ir(5'h11);
        shift_dr(64'h0, 41, dout);
        chk("idle_after_mid_rst", dout, 64'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
